alsu_arbiter: RTL and testbench

Shares one ALSU instance between two requesters. Each requester presents a packed command over a valid/ready handshake. A round-robin arbiter grants one command at a time. The block drives the ALSU input bus for exactly one cycle and holds NOP otherwise, waits out the ALSU pipeline, captures the result and returns it on a shared response channel tagged with the requester id. It sits beside the ALSU in the top level; the ALSU's own inputs are driven only from this block.

---
 rtl/alsu_pkg.sv | 40 ++++
 rtl/alsu_arbiter_if.sv | 25 ++
 rtl/alsu_rr_arb.sv | 20 ++
 rtl/alsu_arbiter.sv | 108 ++++++++++
 tb/tb_alsu_arbiter.sv | 344 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alsu_pkg.sv
// Shared definitions for the ALSU arbiter: command layout, NOP encoding,
// FSM states and the command legality check.
package alsu_pkg;

  localparam int CMD_W = 16;

  // Field offsets inside the packed command, MSB first:
  // {opcode[2:0], A[2:0], B[2:0], cin, red_op_A, red_op_B, bypass_A, bypass_B, direction, serial_in}
  localparam int OPC_LSB   = 13;
  localparam int A_LSB     = 10;
  localparam int B_LSB     = 7;
  localparam int CIN_BIT   = 6;
  localparam int RED_A_BIT = 5;
  localparam int RED_B_BIT = 4;
  localparam int BYP_A_BIT = 3;
  localparam int BYP_B_BIT = 2;
  localparam int DIR_BIT   = 1;
  localparam int SER_BIT   = 0;

  // opcode 0 with A=B=0 drives the ALSU output to zero
  localparam logic [CMD_W-1:0] ALSU_NOP = '0;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    CAPT  = 3'd3,
    RESP  = 3'd4
  } state_t;

  function automatic logic alsu_cmd_invalid(input logic [CMD_W-1:0] cmd);
    logic [2:0] opc;
    logic       any_red;
    opc     = cmd[OPC_LSB +: 3];
    any_red = cmd[RED_A_BIT] | cmd[RED_B_BIT];
    return !cmd[BYP_A_BIT] && !cmd[BYP_B_BIT] &&
           ((opc[2] & opc[1]) || (any_red && (opc[2] | opc[1])));
  endfunction

endpackage

// File: rtl/alsu_arbiter_if.sv
// Request/response bus between the two requesters and the ALSU arbiter.
// Handshake: a transfer happens in a cycle where valid and ready are both high;
// the source holds its payload stable while valid is high and not yet accepted.
interface alsu_arbiter_if;

  logic [1:0]                    req_valid;
  logic [1:0]                    req_ready;
  logic [2*alsu_pkg::CMD_W-1:0]  req_cmd;
  logic                          rsp_valid;
  logic                          rsp_ready;
  logic                          rsp_id;
  logic signed [5:0]             rsp_data;
  logic                          rsp_err;

  modport master (
    output req_valid, req_cmd, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_err
  );

  modport slave (
    input  req_valid, req_cmd, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_data, rsp_err
  );

endinterface

// File: rtl/alsu_rr_arb.sv
// Two-way round-robin arbiter: on contention the requester not granted last wins.
module alsu_rr_arb (
  input  logic [1:0] req,
  input  logic       last_grant,
  input  logic       en,
  output logic [1:0] grant,
  output logic       grant_id
);

  always_comb begin
    grant    = 2'b00;
    grant_id = 1'b0;
    if (en && (req != 2'b00)) begin
      if (req == 2'b11) grant_id = ~last_grant;
      else              grant_id = req[1];
      grant[grant_id] = 1'b1;
    end
  end

endmodule

// File: rtl/alsu_arbiter.sv
// Shares one ALSU between two requesters: grants a command, issues it for a
// single cycle, waits out the ALSU pipeline and returns the tagged result.
module alsu_arbiter
  import alsu_pkg::*;
#(
  parameter int ALSU_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  alsu_arbiter_if.slave     bus,
  output logic [CMD_W-1:0]  alsu_cmd,
  input  logic signed [5:0] alsu_out,
  output logic              busy,
  output logic [7:0]        ops_done,
  output state_t            dbg_state
);

  localparam int CNT_W = (ALSU_LAT > 1) ? $clog2(ALSU_LAT) : 1;

  state_t           state, state_nxt;
  logic [1:0]       grant;
  logic             grant_id;
  logic             accept;
  logic             last_grant;
  logic             pend_id;
  logic             pend_err;
  logic [CNT_W-1:0] cnt;
  logic [CMD_W-1:0] win_cmd;

  // Arbitration is only live in IDLE and never while reset is asserted,
  // so a requester is never told it was accepted by a cycle that gets discarded.
  alsu_rr_arb u_arb (
    .req        (bus.req_valid),
    .last_grant (last_grant),
    .en         ((state == IDLE) && !rst),
    .grant      (grant),
    .grant_id   (grant_id)
  );

  assign bus.req_ready = grant;
  assign accept        = |grant;
  assign win_cmd       = grant_id ? bus.req_cmd[2*CMD_W-1:CMD_W] : bus.req_cmd[CMD_W-1:0];
  assign busy          = (state != IDLE);
  assign dbg_state     = state;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = ISSUE;
      ISSUE:   state_nxt = (ALSU_LAT > 1) ? WAIT : CAPT;
      WAIT:    if (cnt == CNT_W'(1)) state_nxt = CAPT;
      CAPT:    state_nxt = RESP;
      RESP:    if (bus.rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant   <= 1'b1;
      alsu_cmd     <= ALSU_NOP;
      pend_id      <= 1'b0;
      pend_err     <= 1'b0;
      cnt          <= '0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_id   <= 1'b0;
      bus.rsp_data <= '0;
      bus.rsp_err  <= 1'b0;
      ops_done     <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            alsu_cmd   <= win_cmd;
            pend_id    <= grant_id;
            pend_err   <= alsu_cmd_invalid(win_cmd);
            last_grant <= grant_id;
          end
        end
        ISSUE: begin
          // the command is presented for exactly one cycle; NOP keeps the ALSU quiet
          alsu_cmd <= ALSU_NOP;
          cnt      <= CNT_W'(ALSU_LAT - 1);
        end
        WAIT: cnt <= cnt - CNT_W'(1);
        CAPT: begin
          bus.rsp_valid <= 1'b1;
          bus.rsp_data  <= alsu_out;
          bus.rsp_id    <= pend_id;
          bus.rsp_err   <= pend_err;
        end
        RESP: begin
          if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
            ops_done      <= ops_done + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alsu_arbiter.sv
// Bench for alsu_arbiter with a behavioural ALSU (input priority A, full adder on)
// and a transaction-level reference model checked every cycle.
module tb_alsu_arbiter;
  import alsu_pkg::*;

  localparam int LAT     = 2;
  localparam int RESP_PH = LAT + 2;
  localparam int W       = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alsu_arbiter_if bus ();
  logic [CMD_W-1:0]  alsu_cmd;
  logic signed [5:0] alsu_out;
  logic              busy;
  logic [7:0]        ops_done;
  state_t            dbg_state;

  alsu_arbiter #(.ALSU_LAT(LAT)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.slave),
    .alsu_cmd  (alsu_cmd),
    .alsu_out  (alsu_out),
    .busy      (busy),
    .ops_done  (ops_done),
    .dbg_state (dbg_state)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [5:0] sx(input logic [2:0] v);
    return {{3{v[2]}}, v};
  endfunction

  function automatic logic [15:0] mk(input logic [2:0] op, input logic [2:0] a, input logic [2:0] b,
                                     input logic cin, input logic ra, input logic rb,
                                     input logic ba, input logic bb, input logic dir, input logic si);
    return {op, a, b, cin, ra, rb, ba, bb, dir, si};
  endfunction

  // ---------------- behavioural ALSU: input register then output register
  function automatic logic [5:0] alsu_next(input logic [15:0] c, input logic [5:0] cur);
    logic [2:0] op, a, b;
    logic       inval;
    op = c[15:13]; a = c[12:10]; b = c[9:7];
    inval = (op == 3'd6) || (op == 3'd7) || ((c[5] || c[4]) && (op > 3'd1));
    if (c[3]) return sx(a);
    if (c[2]) return sx(b);
    if (inval) return 6'd0;
    case (op)
      3'd0:    return c[5] ? {5'd0, &a} : c[4] ? {5'd0, &b} : (sx(a) & sx(b));
      3'd1:    return c[5] ? {5'd0, ^a} : c[4] ? {5'd0, ^b} : (sx(a) ^ sx(b));
      3'd2:    return sx(a) + sx(b) + {5'd0, c[6]};
      3'd3:    return sx(a) * sx(b);
      3'd4:    return c[1] ? {cur[4:0], c[0]} : {c[0], cur[5:1]};
      3'd5:    return c[1] ? {cur[4:0], cur[5]} : {cur[0], cur[5:1]};
      default: return 6'd0;
    endcase
  endfunction

  logic [CMD_W-1:0] alsu_in_q;
  always @(posedge clk) begin
    if (rst) begin
      alsu_in_q <= '0;
      alsu_out  <= '0;
    end else begin
      alsu_in_q <= alsu_cmd;
      alsu_out  <= alsu_next(alsu_in_q, alsu_out);
    end
  end

  // ---------------- reference model
  function automatic logic ref_err(input logic [15:0] c);
    return !c[3] && !c[2] && ((c[15] && c[14]) || ((c[5] || c[4]) && (c[15] || c[14])));
  endfunction

  // Between operations the ALSU sits at 0, so shift/rotate results are fixed.
  function automatic logic [5:0] alsu_ref(input logic [15:0] c);
    if (c[3]) return sx(c[12:10]);
    if (c[2]) return sx(c[9:7]);
    if (ref_err(c)) return 6'd0;
    if (c[15:13] == 3'd4) return c[0] ? (c[1] ? 6'b000001 : 6'b100000) : 6'd0;
    if (c[15:13] == 3'd5) return 6'd0;
    return alsu_next(c, 6'd0);
  endfunction

  int               m_phase = -1;   // cycles since accept, -1 when idle
  logic             m_last  = 1'b1;
  logic [7:0]       m_ops   = 8'd0;
  logic [CMD_W-1:0] m_cmd   = '0;
  logic [W-1:0]     exp_q[$];
  logic [1:0]       e_ready;
  logic             e_gid;

  always @(negedge clk) begin
    e_ready = 2'b00;
    e_gid   = 1'b0;
    if (m_phase < 0 && !rst && bus.req_valid != 2'b00) begin
      e_gid = (bus.req_valid == 2'b11) ? ~m_last : bus.req_valid[1];
      e_ready[e_gid] = 1'b1;
    end
    chk("req_ready", 32'(bus.req_ready), 32'(e_ready));
    chk("alsu_cmd",  32'(alsu_cmd), (m_phase == 1) ? 32'(m_cmd) : 32'(ALSU_NOP));
    chk("busy",      32'(busy), 32'(m_phase >= 0));
    chk("ops_done",  32'(ops_done), 32'(m_ops));
    chk("rsp_valid", 32'(bus.rsp_valid), 32'(m_phase == RESP_PH));
    if (m_phase == RESP_PH) begin
      if (exp_q.size() == 0) chk("rsp_unexpected", 32'd1, 32'd0);
      else chk("rsp_payload", 32'({bus.rsp_id, bus.rsp_err, bus.rsp_data}), 32'(exp_q[0]));
    end
    if (rst) begin
      m_phase = -1; m_last = 1'b1; m_ops = 8'd0;
      exp_q.delete();
    end else if (m_phase < 0) begin
      if (e_ready != 2'b00) begin
        m_cmd = e_gid ? bus.req_cmd[31:16] : bus.req_cmd[15:0];
        exp_q.push_back({e_gid, ref_err(m_cmd), alsu_ref(m_cmd)});
        m_last  = e_gid;
        m_phase = 1;
      end
    end else if (m_phase < RESP_PH) begin
      m_phase++;
    end else if (bus.rsp_ready) begin
      void'(exp_q.pop_front());
      m_ops++;
      m_phase = -1;
    end
  end

  // ---------------- driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.req_valid = 2'b00;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic wait_accept(output logic gid);
    int n = 0;
    gid = 1'b0;
    forever begin
      @(negedge clk);
      if ((bus.req_valid & bus.req_ready) != 2'b00) begin gid = bus.req_ready[1]; break; end
      if (++n > 50) begin chk("accept_timeout", 32'd0, 32'd1); break; end
    end
  endtask

  task automatic wait_rsp();
    int n = 0;
    forever begin
      @(negedge clk);
      if (bus.rsp_valid) break;
      if (++n > 50) begin chk("rsp_timeout", 32'd0, 32'd1); break; end
    end
  endtask

  task automatic single_op(input logic [1:0] v, input logic [15:0] c,
                           output logic id, output logic err, output logic [5:0] data);
    logic g;
    if (v[0]) bus.req_cmd[15:0]  = c;
    if (v[1]) bus.req_cmd[31:16] = c;
    bus.req_valid = v;
    wait_accept(g);
    tick();
    bus.req_valid = 2'b00;
    wait_rsp();
    id = bus.rsp_id; err = bus.rsp_err; data = $unsigned(bus.rsp_data);
    tick();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] c, c0, c1;
    logic        g, id, err, first;
    logic [5:0]  data;
    logic [7:0]  p;
    logic [1:0]  acc;

    bus.req_valid = 2'b00;
    bus.req_cmd   = '0;
    bus.rsp_ready = 1'b0;
    do_reset();

    // add: 3 + 2 + 1 from req0
    c = mk(3'd2, 3'd3, 3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    bus.req_cmd[15:0] = c;
    bus.rsp_ready = 1'b1;
    bus.req_valid = 2'b01;
    wait_accept(g);
    chk("t1_gid", 32'(g), 32'd0);
    tick();
    bus.req_valid = 2'b00;
    @(negedge clk); chk("t1_cmd_t1", 32'(alsu_cmd), 32'(c));
    @(negedge clk); chk("t1_cmd_t2", 32'(alsu_cmd), 32'd0);
    @(negedge clk); chk("t1_valid_t3", 32'(bus.rsp_valid), 32'd0);
    @(negedge clk);
    chk("t1_valid_t4", 32'(bus.rsp_valid), 32'd1);
    chk("t1_id", 32'(bus.rsp_id), 32'd0);
    chk("t1_data", 32'($unsigned(bus.rsp_data)), 32'd6);
    chk("t1_err", 32'(bus.rsp_err), 32'd0);
    @(negedge clk);
    chk("t1_ops", 32'(ops_done), 32'd1);
    chk("t1_busy", 32'(busy), 32'd0);
    tick();

    // both requesters multiply continuously
    do_reset();
    c0 = mk(3'd3, 3'b110, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    c1 = mk(3'd3, 3'd2,   3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    bus.req_cmd   = {c1, c0};
    bus.rsp_ready = 1'b1;
    bus.req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      wait_rsp();
      chk("t2_id", 32'(bus.rsp_id), 32'(k % 2));
      chk("t2_data", 32'($unsigned(bus.rsp_data)), (k % 2 == 0) ? 32'h3A : 32'h04);
      tick();
    end
    bus.req_valid = 2'b00;
    @(negedge clk); chk("t2_ops", 32'(ops_done), 32'd4);
    tick();

    // invalid opcode from req1
    single_op(2'b10, mk(3'd6, 3'd1, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), id, err, data);
    chk("t3_id", 32'(id), 32'd1);
    chk("t3_err", 32'(err), 32'd1);
    chk("t3_data", 32'(data), 32'd0);

    // bypass A overrides the reduction request
    single_op(2'b01, mk(3'd2, 3'b101, 3'd1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0), id, err, data);
    chk("t4_id", 32'(id), 32'd0);
    chk("t4_err", 32'(err), 32'd0);
    chk("t4_data", 32'(data), 32'h3D);

    // shift left with serial_in from req1
    single_op(2'b10, mk(3'd4, 3'd5, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1), id, err, data);
    chk("t4b_shift", 32'(data), 32'h01);

    // backpressure
    bus.rsp_ready = 1'b0;
    bus.req_cmd   = {c1, c0};
    bus.req_valid = 2'b11;
    wait_rsp();
    first = bus.rsp_id;
    p = {bus.rsp_id, bus.rsp_err, bus.rsp_data};
    for (int k = 0; k < 10; k++) begin
      tick();
      @(negedge clk);
      chk("t5_hold", 32'({bus.rsp_id, bus.rsp_err, bus.rsp_data}), 32'(p));
      chk("t5_valid", 32'(bus.rsp_valid), 32'd1);
      chk("t5_no_ready", 32'(bus.req_ready), 32'd0);
    end
    tick();
    bus.rsp_ready = 1'b1;
    @(negedge clk); chk("t5_hs", 32'(bus.rsp_valid), 32'd1);
    tick();
    @(negedge clk);
    chk("t5_released", 32'(bus.rsp_valid), 32'd0);
    chk("t5_other", 32'(bus.req_ready), first ? 32'd1 : 32'd2);
    tick();
    bus.req_valid = 2'b00;
    wait_rsp();
    tick();

    // reset while waiting on the ALSU
    bus.req_cmd[15:0] = c0;
    bus.req_valid = 2'b01;
    wait_accept(g);
    tick();
    bus.req_valid = 2'b00;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("t6_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("t6_rsp_id", 32'(bus.rsp_id), 32'd0);
    chk("t6_rsp_data", 32'($unsigned(bus.rsp_data)), 32'd0);
    chk("t6_rsp_err", 32'(bus.rsp_err), 32'd0);
    chk("t6_alsu_cmd", 32'(alsu_cmd), 32'd0);
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_ops", 32'(ops_done), 32'd0);
    chk("t6_state", 32'(dbg_state), 32'(IDLE));
    for (int k = 0; k < 6; k++) begin
      @(negedge clk); chk("t6_no_rsp", 32'(bus.rsp_valid), 32'd0);
    end
    tick();
    bus.req_valid = 2'b11;
    @(negedge clk); chk("t6_first_grant", 32'(bus.req_ready), 32'd1);
    tick();
    bus.req_valid = 2'b00;
    wait_rsp();
    tick();

    // randomized traffic with back-pressure and occasional reset pulses
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      acc = bus.req_valid & bus.req_ready;
      tick();
      for (int i = 0; i < 2; i++) begin
        if (acc[i] || !bus.req_valid[i]) begin
          if ($urandom_range(0, 3) != 0) begin
            bus.req_valid[i] = 1'b1;
            bus.req_cmd[i*16 +: 16] = 16'($urandom_range(0, 16'hFFFF));
          end else begin
            bus.req_valid[i] = 1'b0;
          end
        end
      end
      bus.rsp_ready = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 199) == 0);
    end
    rst = 1'b0;
    bus.req_valid = 2'b00;
    bus.rsp_ready = 1'b1;
    repeat (12) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
